cpu_bus_seq: RTL
================

# cpu_bus_seq

Machine-cycle bus sequencer for the LR35902 CPU core. It sits between the instruction decoder/control unit and the external memory bus. It divides every M-cycle into four T-states and runs one read, write or idle bus cycle per M-cycle. It also hosts the 16-bit increment/decrement unit (IDU) that post-modifies the cycle address, used for PC, SP and HLI/HLD. It is the stage that drives `adr`/`dout` and captures `din`, so the address and data checks of the LD-class proofs land on its outputs.

## Interface
Parameters:
- none (bus widths fixed by architecture: 16-bit address, 8-bit data)

Ports:
- `clk`  in  1  system clock; one T-state per enabled edge
- `reset`  in  1  synchronous, active-high reset
- `ce`  in  1  clock enable; low freezes T-state and all registered outputs
- `req_valid`  in  1  control unit offers the next M-cycle bus operation
- `req_write`  in  1  1 = write cycle, 0 = read cycle
- `req_adr`  in  16  address for the next M-cycle
- `req_dout`  in  8  write data for the next M-cycle
- `req_idu`  in  2  IDU op on `req_adr`: 00 none, 01 inc, 10 dec, 11 reserved (treated as none)
- `req_ready`  out  1  high during T4; request accepted on the T4 edge
- `tstate`  out  4  one-hot T1..T4 (bit0 = T1)
- `adr`  out  16  bus address
- `rd`  out  1  read strobe
- `wr`  out  1  write strobe
- `dout`  out  8  write data
- `dout_oe`  out  1  data bus drive enable
- `din`  in  8  read data from bus
- `rdata`  out  8  last captured read byte
- `rdata_valid`  out  1  one-cycle pulse in T4 of a read M-cycle
- `idu_result`  out  16  `adr` ±1
- `idu_wb`  out  1  one-cycle pulse in T3 when IDU op ≠ none

## Operation
- T-state counter is a free-running ring T1→T2→T3→T4→T1, advancing on every edge with `ce`=1.
- Request acceptance:
  - With `req_valid & req_ready & ce` on the T4 edge, latch write, adr, dout and idu; the next M-cycle executes that request.
  - With no request on the T4 edge, the next M-cycle is idle: `adr` holds its previous value, `rd`=`wr`=`dout_oe`=0, no `idu_wb`.
- Read M-cycle:
  - `adr` valid T1–T4.
  - `rd`=1 in T1–T3.
  - `din` is captured into `rdata` on the T3→T4 edge.
  - `rdata_valid`=1 in T4.
  - `rdata` holds until the next capture.
- Write M-cycle:
  - `adr` and `dout` valid T1–T4.
  - `wr`=1 in T2–T3.
  - `dout_oe`=1 in T2–T4.
  - `rdata` is unchanged.
- IDU:
  - `idu_result` = `adr`+1 or `adr`−1, modulo 2^16 (0xFFFF+1 = 0x0000, 0x0000−1 = 0xFFFF).
  - The op is applied to the address used by the current cycle, never to a pending request.
  - `idu_wb` pulses in T3 so the register file holds the updated value by T1 of the next M-cycle.
- `ce`=0: no state change, no strobe edges; outputs hold exactly. `rdata_valid` and `idu_wb` stay at their held level. `ce` stalls only whole edges.
- `reset` dominates `ce` and requests.

## Timing
- Reset values: `tstate`=T1 (0001), `adr`=0x0000, `rd`=0, `wr`=0, `dout`=0x00, `dout_oe`=0, `rdata`=0x00, `rdata_valid`=0, `idu_result`=0x0001, `idu_wb`=0, `req_ready`=0.
- The first M-cycle after reset is idle. The first request can be accepted at its T4 edge (edge 4 after reset release).
- Latency: from request accept to `adr` valid is 1 edge (T1). To `rdata_valid` is 4 edges. To `idu_wb` is 3 edges.
- Back-to-back requests are sustained: one per M-cycle, with no bubble.
- Reset mid-M-cycle:
  - Next cycle is T1 with reset values.
  - The in-flight operation is aborted: no strobes, no `idu_wb`.
  - A latched but unexecuted request is dropped.
- Simultaneous `req_valid` outside T4 is ignored; the request must be held until T4.

## Structure
- Package `cpu_bus_pkg` holds:
  - `tstate_t` one-hot enum (T1..T4)
  - `idu_op_t` enum (NONE, INC, DEC)
  - `bus_req_t` packed struct {write, adr, dout, idu}
- Sub-module `cpu_idu`: combinational 16-bit inc/dec with op input. It is reused by SP arithmetic paths elsewhere.

## Test plan
- Reset then idle: hold `req_valid`=0 for 8 cycles → all outputs stay at reset values; `tstate` cycles 1,2,4,8.
- Read: at T4 accept {read, 0xC000, idu none}; `din`=0x5A in T3 → `adr`=0xC000 T1–T4, `rd` T1–T3, `rdata`=0x5A with `rdata_valid` in T4, no `wr`.
- Write with increment (LD (HLI),A-style): accept {write, 0xFF80, dout 0x22, inc} → `wr` T2–T3, `dout`=0x22, `idu_wb` in T3 with `idu_result`=0xFF81.
- Decrement wrap: write at 0x0000 with dec → `idu_result`=0xFFFF at the `idu_wb` pulse; back-to-back read at 0xFFFF next M-cycle without bubble.
- Stall: drop `ce` for 3 cycles during T2 of a write → `tstate`, `adr`, `wr`=1 and `dout` frozen; cycle resumes at T3 afterwards.
- Reset mid-cycle: assert `reset` in T2 of a read → next cycle T1 with `rd`=0, `adr`=0x0000; no `rdata_valid` or `idu_wb` follows.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types for the LR35902 M-cycle bus sequencer.
// T-state ring, IDU op encoding and the latched bus request bundle.
package cpu_bus_pkg;

  typedef enum logic [3:0] {
    T1 = 4'b0001,
    T2 = 4'b0010,
    T3 = 4'b0100,
    T4 = 4'b1000
  } tstate_t;

  typedef enum logic [1:0] {
    IDU_NONE = 2'b00,
    IDU_INC  = 2'b01,
    IDU_DEC  = 2'b10
  } idu_op_t;

  typedef struct packed {
    logic        write;
    logic [15:0] adr;
    logic [7:0]  dout;
    idu_op_t     idu;
  } bus_req_t;

  // The reserved encoding 11 collapses to NONE.
  function automatic idu_op_t idu_decode(logic [1:0] raw);
    idu_op_t op;
    op = IDU_NONE;
    unique case (1'b1)
      raw == 2'b01: op = IDU_INC;
      raw == 2'b10: op = IDU_DEC;
      default:      op = IDU_NONE;
    endcase
    return op;
  endfunction

  function automatic tstate_t t_next(tstate_t t);
    tstate_t n;
    n = T1;
    unique case (1'b1)
      t == T1: n = T2;
      t == T2: n = T3;
      t == T3: n = T4;
      default: n = T1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/cpu_bus_seq_if.sv
// Request handshake and external memory bus of the M-cycle sequencer.
// slave = the sequencer, master = control unit plus memory side.
interface cpu_bus_seq_if;
  logic        req_valid;
  logic        req_write;
  logic [15:0] req_adr;
  logic [7:0]  req_dout;
  logic [1:0]  req_idu;
  logic        req_ready;
  logic [3:0]  tstate;
  logic [15:0] adr;
  logic        rd;
  logic        wr;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [7:0]  din;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic [15:0] idu_result;
  logic        idu_wb;

  modport slave (
    input  req_valid, req_write, req_adr, req_dout, req_idu, din,
    output req_ready, tstate, adr, rd, wr, dout, dout_oe,
    output rdata, rdata_valid, idu_result, idu_wb
  );

  modport master (
    output req_valid, req_write, req_adr, req_dout, req_idu, din,
    input  req_ready, tstate, adr, rd, wr, dout, dout_oe,
    input  rdata, rdata_valid, idu_result, idu_wb
  );
endinterface

// File: rtl/cpu_idu.sv
// 16-bit increment/decrement unit, wraps modulo 2^16.
// Shared with the SP arithmetic paths.
module cpu_idu
  import cpu_bus_pkg::*;
(
  input  logic [15:0] a,
  input  idu_op_t     op,
  output logic [15:0] y
);

  always_comb begin
    y = a;
    unique case (1'b1)
      op == IDU_INC: y = a + 16'd1;
      op == IDU_DEC: y = a - 16'd1;
      default:       y = a;
    endcase
  end

endmodule

// File: rtl/cpu_bus_seq.sv
// LR35902 M-cycle bus sequencer: T1..T4 ring, one bus op per M-cycle,
// address post-modify through the IDU.
module cpu_bus_seq
  import cpu_bus_pkg::*;
(
  input logic         clk,
  input logic         reset,
  input logic         ce,
  cpu_bus_seq_if.slave bus
);

  tstate_t  t_q;
  tstate_t  t_n;
  bus_req_t cur_q;
  bus_req_t cur_n;
  bus_req_t req;
  logic     act_q;
  logic     act_n;
  logic     rd_q;
  logic     wr_q;
  logic     oe_q;
  logic     rv_q;
  logic     wb_q;
  logic [7:0] rdata_q;
  idu_op_t  idu_eff;

  assign req = '{
    write: bus.req_write,
    adr:   bus.req_adr,
    dout:  bus.req_dout,
    idu:   idu_decode(bus.req_idu)
  };

  assign t_n = t_next(t_q);

  always_comb begin
    cur_n = cur_q;
    act_n = act_q;
    if (t_q == T4) begin
      act_n = bus.req_valid;
      if (bus.req_valid) begin
        cur_n = req;
      end else begin
        cur_n.write = 1'b0;
        cur_n.idu   = IDU_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      t_q     <= T1;
      cur_q   <= '0;
      act_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oe_q    <= 1'b0;
      rv_q    <= 1'b0;
      wb_q    <= 1'b0;
      rdata_q <= 8'h00;
    end else if (ce) begin
      t_q   <= t_n;
      cur_q <= cur_n;
      act_q <= act_n;
      rd_q  <= act_n & ~cur_n.write & (t_n != T4);
      wr_q  <= act_n & cur_n.write
             & ((t_n == T2) | (t_n == T3));
      oe_q  <= act_n & cur_n.write & (t_n != T1);
      rv_q  <= act_n & ~cur_n.write & (t_n == T4);
      wb_q  <= act_n & (cur_n.idu != IDU_NONE)
             & (t_n == T3);
      if (act_q & ~cur_q.write & (t_q == T3))
        rdata_q <= bus.din;
    end
  end

  // Without a pending decrement the result still reads as adr+1.
  assign idu_eff = (cur_q.idu == IDU_DEC) ? IDU_DEC : IDU_INC;

  cpu_idu u_idu (
    .a  (cur_q.adr),
    .op (idu_eff),
    .y  (bus.idu_result)
  );

  assign bus.req_ready   = (t_q == T4);
  assign bus.tstate      = t_q;
  assign bus.adr         = cur_q.adr;
  assign bus.dout        = cur_q.dout;
  assign bus.rd          = rd_q;
  assign bus.wr          = wr_q;
  assign bus.dout_oe     = oe_q;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rv_q;
  assign bus.idu_wb      = wb_q;

endmodule
